// File: rtl/conv1d_sequencer.sv
// Run sequencer for the Conv1D engine: clear, weight/input/partial-sum load, compute, write-back.
// Outputs are flopped from the next-state decode (zero added latency); start is ignored while busy.
module conv1d_sequencer #(
  parameter int Weight_Nums             = 4,
  parameter int Output_Nums             = 8,
  parameter int Input_Nums              = Output_Nums + Weight_Nums - 1,
  parameter int Nums_Pipeline_Stages    = 4,
  parameter int Pipeline_Tail           = Nums_Pipeline_Stages - 1,
  parameter int Total_Computation_Steps = Weight_Nums * Output_Nums + Pipeline_Tail,
  parameter int Cnt_Width               = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       Accumulate_Existing,
  output logic       busy,
  output logic       done,
  output logic [3:0] state,
  output logic       Mem_Reset,
  output logic       L0_Reset,
  output logic       Comp_Reset,
  output logic       PE_reset,
  output logic       Mem_Weight_Index_Reset,
  output logic       Mem_Input_Index_Reset,
  output logic       Mem_Output_Index_Reset,
  output logic       Weight_Loading_Signal,
  output logic       Input_Loading_Signal,
  output logic       Output_Loading_Signal,
  output logic       Computing_Signal,
  output logic       Output_Writing_Signal
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,  S_CLR     = 4'd1,
    S_WL_PREP = 4'd2,  S_WL_RUN  = 4'd3,
    S_IL_PREP = 4'd4,  S_IL_RUN  = 4'd5,
    S_OL_PREP = 4'd6,  S_OL_RUN  = 4'd7,
    S_CP_PREP = 4'd8,  S_CP_RUN  = 4'd9,
    S_OW_PREP = 4'd10, S_OW_RUN  = 4'd11,
    S_DONE    = 4'd12
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic mem_rst;
    logic l0_rst;
    logic comp_rst;
    logic pe_rst;
    logic w_idx_rst;
    logic i_idx_rst;
    logic o_idx_rst;
    logic wl;
    logic il;
    logic ol;
    logic cp;
    logic ow;
  } outs_t;

  localparam int CntSpan = 2 ** Cnt_Width;
  localparam logic [Cnt_Width-1:0] WlLast = Cnt_Width'(Weight_Nums - 1);
  localparam logic [Cnt_Width-1:0] IlLast = Cnt_Width'(Input_Nums - 1);
  localparam logic [Cnt_Width-1:0] OlLast = Cnt_Width'(Output_Nums - 1);
  localparam logic [Cnt_Width-1:0] CpLast = Cnt_Width'(Total_Computation_Steps - 1);
  localparam logic [Cnt_Width-1:0] OwLast = Cnt_Width'(Output_Nums - 1);

  state_t               r_state, w_next_state;
  logic [Cnt_Width-1:0] r_cnt, w_next_cnt;
  logic                 r_acc, w_next_acc;
  outs_t                r_outs;

  function automatic outs_t decode(input state_t s);
    outs_t o;
    o      = '0;
    o.busy = (s != S_IDLE);
    case (s)
      S_CLR:     begin o.mem_rst = 1'b1; o.l0_rst = 1'b1; o.comp_rst = 1'b1; o.pe_rst = 1'b1; end
      S_WL_PREP: o.w_idx_rst = 1'b1;
      S_WL_RUN:  o.wl = 1'b1;
      S_IL_PREP: o.i_idx_rst = 1'b1;
      S_IL_RUN:  o.il = 1'b1;
      S_OL_PREP: o.o_idx_rst = 1'b1;
      S_OL_RUN:  o.ol = 1'b1;
      S_CP_PREP: begin o.comp_rst = 1'b1; o.pe_rst = 1'b1; end
      S_CP_RUN:  o.cp = 1'b1;
      S_OW_PREP: o.o_idx_rst = 1'b1;
      S_OW_RUN:  o.ow = 1'b1;
      S_DONE:    o.done = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_outs  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_acc   <= w_next_acc;
      r_outs  <= decode(w_next_state);
    end
  end

  // Each RUN state holds while the counter walks 0..N-1; PREP states rearm the counter.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_acc   = r_acc;
    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (start) begin
          w_next_state = S_CLR;
          w_next_acc   = Accumulate_Existing;
        end
      end
      S_CLR:     w_next_state = S_WL_PREP;
      S_WL_PREP: begin w_next_cnt = '0; w_next_state = S_WL_RUN; end
      S_WL_RUN:  if (r_cnt == WlLast) w_next_state = S_IL_PREP; else w_next_cnt = r_cnt + 1'b1;
      S_IL_PREP: begin w_next_cnt = '0; w_next_state = S_IL_RUN; end
      S_IL_RUN:  if (r_cnt == IlLast) w_next_state = r_acc ? S_OL_PREP : S_CP_PREP;
                 else w_next_cnt = r_cnt + 1'b1;
      S_OL_PREP: begin w_next_cnt = '0; w_next_state = S_OL_RUN; end
      S_OL_RUN:  if (r_cnt == OlLast) w_next_state = S_CP_PREP; else w_next_cnt = r_cnt + 1'b1;
      S_CP_PREP: begin w_next_cnt = '0; w_next_state = S_CP_RUN; end
      S_CP_RUN:  if (r_cnt == CpLast) w_next_state = S_OW_PREP; else w_next_cnt = r_cnt + 1'b1;
      S_OW_PREP: begin w_next_cnt = '0; w_next_state = S_OW_RUN; end
      S_OW_RUN:  if (r_cnt == OwLast) w_next_state = S_DONE; else w_next_cnt = r_cnt + 1'b1;
      S_DONE:    w_next_state = S_IDLE;
      default:   begin w_next_state = S_IDLE; w_next_cnt = '0; end
    endcase
    // Abort beats everything, including a start arriving in IDLE.
    if (abort) begin
      w_next_state = S_IDLE;
      w_next_cnt   = '0;
      w_next_acc   = r_acc;
    end
  end

  always_ff @(posedge clk) begin
    assert (Total_Computation_Steps <= CntSpan && Input_Nums <= CntSpan);
  end

  assign state                  = r_state;
  assign busy                   = r_outs.busy;
  assign done                   = r_outs.done;
  assign Mem_Reset              = r_outs.mem_rst;
  assign L0_Reset               = r_outs.l0_rst;
  assign Comp_Reset             = r_outs.comp_rst;
  assign PE_reset               = r_outs.pe_rst;
  assign Mem_Weight_Index_Reset = r_outs.w_idx_rst;
  assign Mem_Input_Index_Reset  = r_outs.i_idx_rst;
  assign Mem_Output_Index_Reset = r_outs.o_idx_rst;
  assign Weight_Loading_Signal  = r_outs.wl;
  assign Input_Loading_Signal   = r_outs.il;
  assign Output_Loading_Signal  = r_outs.ol;
  assign Computing_Signal       = r_outs.cp;
  assign Output_Writing_Signal  = r_outs.ow;

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Bench for conv1d_sequencer: scenario table, hand-written corner sequences and random stimulus
// compared every cycle against a phase-schedule reference model.
module tb_conv1d_sequencer;

  localparam int WN  = 4;
  localparam int ON  = 8;
  localparam int IN  = WN + ON - 1;
  localparam int TCS = WN * ON + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       Accumulate_Existing = 1'b0;
  logic       busy, done;
  logic [3:0] state;
  logic       Mem_Reset, L0_Reset, Comp_Reset, PE_reset;
  logic       Mem_Weight_Index_Reset, Mem_Input_Index_Reset, Mem_Output_Index_Reset;
  logic       Weight_Loading_Signal, Input_Loading_Signal, Output_Loading_Signal;
  logic       Computing_Signal, Output_Writing_Signal;
  logic [13:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  int sched[$];
  int pos     = 0;
  bit running = 1'b0;

  always #5 clk = ~clk;

  conv1d_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .Accumulate_Existing(Accumulate_Existing),
    .busy(busy), .done(done), .state(state),
    .Mem_Reset(Mem_Reset), .L0_Reset(L0_Reset), .Comp_Reset(Comp_Reset), .PE_reset(PE_reset),
    .Mem_Weight_Index_Reset(Mem_Weight_Index_Reset),
    .Mem_Input_Index_Reset(Mem_Input_Index_Reset),
    .Mem_Output_Index_Reset(Mem_Output_Index_Reset),
    .Weight_Loading_Signal(Weight_Loading_Signal),
    .Input_Loading_Signal(Input_Loading_Signal),
    .Output_Loading_Signal(Output_Loading_Signal),
    .Computing_Signal(Computing_Signal),
    .Output_Writing_Signal(Output_Writing_Signal)
  );

  assign outs = {busy, done, Mem_Reset, L0_Reset, Comp_Reset, PE_reset,
                 Mem_Weight_Index_Reset, Mem_Input_Index_Reset, Mem_Output_Index_Reset,
                 Weight_Loading_Signal, Input_Loading_Signal, Output_Loading_Signal,
                 Computing_Signal, Output_Writing_Signal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output bits for each state code, same bit order as 'outs'.
  function automatic logic [13:0] exp_outs(input int code);
    logic [13:0] v;
    v     = '0;
    v[13] = (code != 0);
    case (code)
      1:  v[11:8] = 4'hF;
      2:  v[7] = 1'b1;
      3:  v[4] = 1'b1;
      4:  v[6] = 1'b1;
      5:  v[3] = 1'b1;
      6:  v[5] = 1'b1;
      7:  v[2] = 1'b1;
      8:  v[9:8] = 2'b11;
      9:  v[1] = 1'b1;
      10: v[5] = 1'b1;
      11: v[0] = 1'b1;
      12: v[12] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // A run is a flat list of per-cycle state codes: segments of fixed length in phase order.
  task automatic model_build(input bit acc);
    sched.delete();
    sched.push_back(1);
    sched.push_back(2);  repeat (WN)  sched.push_back(3);
    sched.push_back(4);  repeat (IN)  sched.push_back(5);
    if (acc) begin
      sched.push_back(6); repeat (ON) sched.push_back(7);
    end
    sched.push_back(8);  repeat (TCS) sched.push_back(9);
    sched.push_back(10); repeat (ON)  sched.push_back(11);
    sched.push_back(12);
  endtask

  task automatic model_step(input bit st, input bit ab, input bit ac);
    if (running) begin
      if (ab) running = 1'b0;
      else begin
        pos++;
        if (pos >= sched.size()) running = 1'b0;
      end
    end else if (st && !ab) begin
      model_build(ac);
      pos     = 0;
      running = 1'b1;
    end
  endtask

  task automatic cyc_step(input bit st, input bit ab, input bit ac);
    int          code;
    logic [17:0] expv;
    start = st; abort = ab; Accumulate_Existing = ac;
    @(posedge clk); #1;
    model_step(st, ab, ac);
    code = running ? sched[pos] : 0;
    expv = {4'(code), exp_outs(code)};
    chk("state_outs", 32'({state, outs}), 32'(expv));
    chk("phase_excl", 32'($countones(outs[4:0]) <= 1), 32'd1);
  endtask

  typedef struct {
    bit acc;
    int abort_at;
    int done_cyc;
    int n_wl, n_il, n_ol, n_cp, n_ow;
    int n_busy;
  } scen_t;

  task automatic run_scenario(input scen_t r);
    int wl = 0, il = 0, ol = 0, cp = 0, ow = 0, bz = 0, dc = 0, nd = 0;
    cyc_step(1'b1, 1'b0, r.acc);
    for (int c = 1; c <= 95; c++) begin
      wl += int'(Weight_Loading_Signal);
      il += int'(Input_Loading_Signal);
      ol += int'(Output_Loading_Signal);
      cp += int'(Computing_Signal);
      ow += int'(Output_Writing_Signal);
      bz += int'(busy);
      if (done) begin dc = c; nd++; end
      cyc_step(1'b0, c == r.abort_at, 1'b0);
    end
    chk("scn_wl", 32'(wl), 32'(r.n_wl));
    chk("scn_il", 32'(il), 32'(r.n_il));
    chk("scn_ol", 32'(ol), 32'(r.n_ol));
    chk("scn_cp", 32'(cp), 32'(r.n_cp));
    chk("scn_ow", 32'(ow), 32'(r.n_ow));
    chk("scn_busy", 32'(bz), 32'(r.n_busy));
    chk("scn_done_cyc", 32'(dc), 32'(r.done_cyc));
    chk("scn_done_cnt", 32'(nd), (r.done_cyc != 0) ? 32'd1 : 32'd0);
  endtask

  scen_t tbl[8];
  int    hist[0:80];
  int    bnd_cyc[11];
  int    bnd_code[11];

  initial begin
    tbl[0] = '{1'b1,  0, 73, 4, 11, 8, 35, 8, 73};
    tbl[1] = '{1'b0,  0, 64, 4, 11, 0, 35, 8, 64};
    tbl[2] = '{1'b1, 40,  0, 4, 11, 8, 12, 0, 40};
    tbl[3] = '{1'b0, 10,  0, 4,  3, 0,  0, 0, 10};
    tbl[4] = '{1'b0,  1,  0, 0,  0, 0,  0, 0,  1};
    tbl[5] = '{1'b1, 25,  0, 4, 11, 6,  0, 0, 25};
    tbl[6] = '{1'b0, 50,  0, 4, 11, 0, 31, 0, 50};
    tbl[7] = '{1'b1, 70,  0, 4, 11, 8, 35, 6, 70};
    bnd_cyc  = '{2, 3, 6, 7, 18, 19, 28, 29, 63, 64, 72};
    bnd_code = '{2, 3, 3, 4,  5,  6,  8,  9,  9, 10, 11};

    // Reset held, then idle with start low.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state_outs", 32'({state, outs}), 32'd0);
    reset = 1'b0;
    running = 1'b0;
    for (int i = 0; i < 10; i++) cyc_step(1'b0, 1'b0, 1'b0);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) run_scenario(tbl[i]);

    // Start held high: run boundaries, DONE, then a single IDLE cycle before restart.
    for (int c = 1; c <= 76; c++) begin
      cyc_step(1'b1, 1'b0, 1'b1);
      hist[c] = int'(state);
    end
    for (int i = 0; i < 11; i++) chk("held_boundary", 32'(hist[bnd_cyc[i]]), 32'(bnd_code[i]));
    chk("held_done_state", 32'(hist[73]), 32'd12);
    chk("held_idle_gap", 32'(hist[74]), 32'd0);
    chk("held_restart", 32'(hist[75]), 32'd1);
    cyc_step(1'b0, 1'b1, 1'b0);
    cyc_step(1'b0, 1'b0, 1'b0);

    // Start pulses while busy are ignored.
    begin
      int dc = 0;
      cyc_step(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 70; c++) begin
        if (done) dc = c;
        cyc_step(c == 5 || c == 30, 1'b0, 1'b0);
      end
      chk("busy_start_done_cyc", 32'(dc), 32'd64);
    end

    // Start and abort together in IDLE.
    for (int i = 0; i < 3; i++) cyc_step(1'b1, 1'b1, 1'b1);
    chk("start_abort_idle", 32'(state), 32'd0);
    cyc_step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the input-load phase.
    cyc_step(1'b1, 1'b0, 1'b1);
    for (int c = 2; c <= 12; c++) cyc_step(1'b0, 1'b0, 1'b0);
    chk("pre_rst_il_run", 32'(state), 32'd5);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_outs", 32'({state, outs}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    running = 1'b0;
    cyc_step(1'b0, 1'b0, 1'b0);
    run_scenario(tbl[0]);

    // Random start/abort/acc traffic against the model.
    for (int i = 0; i < 3000; i++)
      cyc_step($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
